playfield_sequencer: RTL and testbench

Game-phase controller for the Tetris playfield datapath. It issues the gravity step enables that advance the falling piece and arbitrates player move requests against those steps. After a lock it scans the settled matrix one row per cycle, commands the row shifts for full lines, and keeps the score. It then requests the next piece and detects game over. It sits between the input/piece-generator logic and the playfield settling datapath, replacing free-running clock enables and the combinational all-rows clear.

---
 rtl/playfield_sequencer_if.sv | 41 ++++
 rtl/playfield_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_playfield_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/playfield_sequencer_if.sv
// -----------------------------------------------------------------------------
// playfield_sequencer_if
// Handshake bundle between the game-phase sequencer and the playfield
// settling datapath / input logic.
//
// Signals:
//   move_req    player move/rotate request, held until granted
//   move_grant  one-cycle grant; the datapath applies the move this cycle
//   step_ce     one-cycle gravity step pulse
//   landed      datapath pulse: piece written into the matrix
//   row_sel     row address during scan/shift
//   row_full    AND of matrix row row_sel
//   shift_en    rows 1..row_sel take the row above, row 0 cleared
//   spawn       one-cycle request to the piece generator
//   top_blocked spawn rows occupied
//
// Modports:
//   master  sequencer side (drives grants, steps, row control, spawn)
//   slave   datapath / input side
// -----------------------------------------------------------------------------
interface playfield_sequencer_if;
  logic       move_req;
  logic       move_grant;
  logic       step_ce;
  logic       landed;
  logic [4:0] row_sel;
  logic       row_full;
  logic       shift_en;
  logic       spawn;
  logic       top_blocked;

  modport master (
    input  move_req, landed, row_full, top_blocked,
    output move_grant, step_ce, row_sel, shift_en, spawn
  );

  modport slave (
    output move_req, landed, row_full, top_blocked,
    input  move_grant, step_ce, row_sel, shift_en, spawn
  );
endinterface

// File: rtl/playfield_sequencer.sv
// -----------------------------------------------------------------------------
// playfield_sequencer
// Game-phase controller for the Tetris playfield datapath: gravity step
// enables, move arbitration, row-by-row line scan and shift, scoring, piece
// spawn requests and game-over detection.
//
// Parameters:
//   TICK_DIV  gravity period in clk cycles (>= 2)
//   FAST_DIV  soft-drop period in clk cycles (2 <= FAST_DIV <= TICK_DIV)
//   ROWS      visible playfield rows
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   start      begin a new game (honoured in IDLE and OVER)
//   soft_drop  level; selects FAST_DIV as the gravity period
//   bus        playfield_sequencer_if.master handshake bundle
//   game_over  high while in OVER
//   score      lines cleared, saturating at 0xFFFF
//   state      current state encoding (IDLE=0 .. OVER=5)
//
// Optional feature (macro SEQ_LEVEL_SPEEDUP_EN):
//   defined   every 10 cleared lines the gravity period shrinks by
//             TICK_DIV/16, floored at FAST_DIV
//   undefined gravity period is the constant TICK_DIV
//
// The spawn request is decided in the SPAWN cycle from top_blocked and, being
// registered, appears in the first FALL cycle.
// -----------------------------------------------------------------------------
module playfield_sequencer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int FAST_DIV = 5_000_000,
  parameter int ROWS     = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  soft_drop,
  playfield_sequencer_if.master bus,
  output logic                  game_over,
  output logic [15:0]           score,
  output logic [2:0]            state
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);
  localparam logic [PW-1:0] P_FAST  = PW'(FAST_DIV);
  localparam logic [4:0]    ROW_TOP = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_FALL  = 3'd2,
    S_SCAN  = 3'd3,
    S_SHIFT = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_tick;
  logic            r_step;
  logic            r_spawn;
  logic            r_shift;
  logic            r_over;
  logic [4:0]      r_row;
  logic [15:0]     r_score;
  logic [PW-1:0]   w_period;
  logic [PW-1:0]   w_div;
  logic            w_tick_done;
  logic            w_grant;

`ifdef SEQ_LEVEL_SPEEDUP_EN
  localparam logic [PW-1:0] P_DEC   = PW'(TICK_DIV / 16);
  localparam logic [PW:0]   P_FLOOR = (PW + 1)'(FAST_DIV + TICK_DIV / 16);
  logic [PW-1:0] r_period;
  logic [3:0]    r_lines;
  assign w_period = r_period;
`else
  assign w_period = PW'(TICK_DIV);
`endif

  // Effective step period and the ">=" terminal count, so a soft_drop raised
  // mid-count steps on the next cycle.
  always_comb begin
    if (soft_drop) begin
      w_div = P_FAST;
    end else begin
      w_div = w_period;
    end
    w_tick_done = (PW'(r_tick) >= (w_div - P_ONE));
  end

  // Move grant: only in FALL, yields to a pending step and to landed.
  always_comb begin
    w_grant = 1'b0;
    if ((r_state == S_FALL) && !bus.landed) begin
      w_grant = bus.move_req & ~r_step;
    end else begin
      w_grant = 1'b0;
    end
  end

  // Phase FSM with registered pulse outputs, row pointer, score and level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_step  <= 1'b0;
      r_spawn <= 1'b0;
      r_shift <= 1'b0;
      r_over  <= 1'b0;
      r_row   <= 5'd0;
      r_score <= 16'd0;
`ifdef SEQ_LEVEL_SPEEDUP_EN
      r_period <= PW'(TICK_DIV);
      r_lines  <= 4'd0;
`endif
    end else begin
      r_step  <= 1'b0;
      r_spawn <= 1'b0;
      r_shift <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_SPAWN;
        end
        S_SPAWN: begin
          r_tick <= '0;
          if (bus.top_blocked) begin
            r_state <= S_OVER;
            r_over  <= 1'b1;
          end else begin
            r_state <= S_FALL;
            r_spawn <= 1'b1;
          end
        end
        S_FALL: begin
          if (bus.landed) begin
            r_state <= S_SCAN;
            r_row   <= ROW_TOP;
          end else if (w_tick_done) begin
            r_step <= 1'b1;
            r_tick <= '0;
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_SCAN: begin
          if (bus.row_full) begin
            r_state <= S_SHIFT;
            r_shift <= 1'b1;
          end else if (r_row == 5'd0) begin
            r_state <= S_SPAWN;
          end else begin
            r_row <= r_row - 5'd1;
          end
        end
        S_SHIFT: begin
          // row_sel is held so the row that just moved down is re-examined.
          r_state <= S_SCAN;
          if (r_score != 16'hFFFF) r_score <= r_score + 16'd1;
`ifdef SEQ_LEVEL_SPEEDUP_EN
          if (r_lines == 4'd9) begin
            r_lines <= 4'd0;
            if ({1'b0, r_period} > P_FLOOR) r_period <= r_period - P_DEC;
            else                            r_period <= P_FAST;
          end else begin
            r_lines <= r_lines + 4'd1;
          end
`endif
        end
        S_OVER: begin
          if (start) begin
            r_state <= S_SPAWN;
            r_over  <= 1'b0;
            r_score <= 16'd0;
`ifdef SEQ_LEVEL_SPEEDUP_EN
            r_period <= PW'(TICK_DIV);
            r_lines  <= 4'd0;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.move_grant = w_grant;
  assign bus.step_ce    = r_step;
  assign bus.row_sel    = r_row;
  assign bus.shift_en   = r_shift;
  assign bus.spawn      = r_spawn;
  assign game_over      = r_over;
  assign score          = r_score;
  assign state          = r_state;

endmodule

// File: tb/tb_playfield_sequencer.sv
// -----------------------------------------------------------------------------
// tb_playfield_sequencer
// Directed bench for playfield_sequencer (TICK_DIV=8, FAST_DIV=2, ROWS=20).
// A phase-level model predicts every output each cycle; the scan phase is
// predicted as a precomputed trace built from a copy of the matrix at lock
// time. A small matrix stand-in drives row_full and applies shift_en.
// -----------------------------------------------------------------------------
module tb_playfield_sequencer;
  localparam int ROWS = 20;
  localparam int TICK = 8;
  localparam int FAST = 2;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        start     = 1'b0;
  logic        soft_drop = 1'b0;
  logic        game_over;
  logic [15:0] score;
  logic [2:0]  state;
  bit   [31:0] mat = '0;

  int n_checks = 0;
  int n_errors = 0;

  playfield_sequencer_if bus();

  playfield_sequencer #(.TICK_DIV(TICK), .FAST_DIV(FAST), .ROWS(ROWS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .soft_drop (soft_drop),
    .bus       (bus.master),
    .game_over (game_over),
    .score     (score),
    .state     (state)
  );

  assign bus.row_full = mat[bus.row_sel];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {int st; int row;} ent_t;
  ent_t q[$];
  int e_state = 0, e_row = 0, e_score = 0, since = 0;
  bit e_step = 0, e_spawn = 0, e_shift = 0, m_valid = 0;

  // Expected scan trace: (state,row) per cycle, shifting a private copy.
  task automatic build_scan();
    bit [31:0] m;
    int r;
    m = mat;
    r = ROWS - 1;
    q.delete();
    forever begin
      if (m[r]) begin
        q.push_back('{st: 3, row: r});
        q.push_back('{st: 4, row: r});
        for (int i = r; i > 0; i--) m[i] = m[i-1];
        m[0] = 1'b0;
      end else begin
        q.push_back('{st: 3, row: r});
        if (r == 0) break;
        r--;
      end
    end
  endtask

  initial begin : model
    ent_t e;
    int   dv;
    forever begin
      @(posedge clk);
      if (reset) begin
        e_state = 0; e_row = 0; e_score = 0; since = 0;
        e_step = 0; e_spawn = 0; e_shift = 0;
        q.delete();
        m_valid = 1;
      end else begin
        e_step = 0; e_spawn = 0; e_shift = 0;
        if (e_state == 4 && e_score < 65535) e_score++;
        dv = soft_drop ? FAST : TICK;
        case (e_state)
          0: if (start) e_state = 1;
          1: begin
            since = 0;
            if (bus.top_blocked) e_state = 5;
            else begin e_state = 2; e_spawn = 1; end
          end
          2: begin
            if (bus.landed) begin
              build_scan();
              e = q.pop_front();
              e_state = e.st; e_row = e.row;
            end else begin
              since++;
              if (since >= dv) begin e_step = 1; since = 0; end
            end
          end
          3, 4: begin
            if (q.size() > 0) begin
              e = q.pop_front();
              e_state = e.st; e_row = e.row;
              e_shift = (e.st == 4);
            end else e_state = 1;
          end
          5: if (start) begin e_state = 1; e_score = 0; end
          default: e_state = 0;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin : cmp
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("state",      32'(state),          32'(e_state));
        chk("row_sel",    32'(bus.row_sel),    32'(e_row));
        chk("score",      32'(score),          32'(e_score));
        chk("step_ce",    32'(bus.step_ce),    32'(e_step));
        chk("spawn",      32'(bus.spawn),      32'(e_spawn));
        chk("shift_en",   32'(bus.shift_en),   32'(e_shift));
        chk("game_over",  32'(game_over),      32'(e_state == 5));
        chk("move_grant", 32'(bus.move_grant),
            32'(e_state == 2 && bus.move_req === 1'b1 && !e_step && bus.landed !== 1'b1));
      end
    end
  end

  // Matrix stand-in: applies the shift commanded in a SHIFT cycle.
  initial begin : matrix
    int r;
    forever begin
      @(negedge clk);
      if (bus.shift_en === 1'b1) begin
        r = int'(bus.row_sel);
        for (int i = r; i > 0; i--) mat[i] = mat[i-1];
        mat[0] = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic measure_step(input string name, input int exp);
    bit found;
    int n;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = (bus.step_ce === 1'b1);
    end
    chk({name, "_seen"}, 32'(found), 32'd1);
    found = 0;
    n = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      n++;
      found = (bus.step_ce === 1'b1);
    end
    chk(name, 32'(n), 32'(exp));
  endtask

  task automatic run_scan(output int nscan, output int nshift19, output int first_row,
                          output int last_row, output bit got_spawn);
    nscan = 0; nshift19 = 0; first_row = -1; last_row = -1; got_spawn = 0;
    @(posedge clk); #1 bus.landed = 1'b1;
    @(posedge clk); #1 bus.landed = 1'b0;
    for (int i = 0; i < 80 && !got_spawn; i++) begin
      @(negedge clk);
      if (state == 3'd3 || state == 3'd4) begin
        if (nscan == 0) first_row = int'(bus.row_sel);
        nscan++;
        if (state == 3'd3) last_row = int'(bus.row_sel);
      end
      if (bus.shift_en === 1'b1 && bus.row_sel == 5'd19) nshift19++;
      if (bus.spawn === 1'b1) got_spawn = 1;
    end
  endtask

  initial begin : stim
    int nscan, nsh, fr, lr;
    bit sp, found;
    bus.move_req = 1'b0; bus.landed = 1'b0; bus.top_blocked = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_over",  32'(game_over), 32'd0);
    chk("rst_row",   32'(bus.row_sel), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Start: SPAWN cycle, then spawn pulse in the first FALL cycle.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("spawn_state", 32'(state), 32'd1);
    @(negedge clk);
    chk("spawn_pulse", 32'(bus.spawn), 32'd1);
    chk("fall_state",  32'(state), 32'd2);
    @(negedge clk);
    chk("spawn_once",  32'(bus.spawn), 32'd0);

    measure_step("step_period", 8);
    @(posedge clk); #1 soft_drop = 1'b1;
    measure_step("fast_period", 2);
    @(posedge clk); #1 soft_drop = 1'b0;

    // Move held across a step.
    @(posedge clk); #1 bus.move_req = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = (bus.step_ce === 1'b1);
    end
    chk("grant_step_seen", 32'(found), 32'd1);
    chk("grant_in_step", 32'(bus.move_grant), 32'd0);
    @(negedge clk);
    chk("grant_after_step", 32'(bus.move_grant), 32'd1);
    @(posedge clk); #1 bus.move_req = 1'b0;

    // Lock with no full rows.
    run_scan(nscan, nsh, fr, lr, sp);
    chk("scanA_spawn", 32'(sp), 32'd1);
    chk("scanA_cycles", 32'(nscan), 32'd20);
    chk("scanA_first", 32'(fr), 32'd19);
    chk("scanA_last", 32'(lr), 32'd0);
    chk("scanA_score", 32'(score), 32'd0);

    // Lock with rows 19 and 18 full.
    mat[19] = 1'b1; mat[18] = 1'b1;
    run_scan(nscan, nsh, fr, lr, sp);
    chk("scanB_spawn", 32'(sp), 32'd1);
    chk("scanB_cycles", 32'(nscan), 32'd24);
    chk("scanB_shift19", 32'(nsh), 32'd2);
    chk("scanB_score", 32'(score), 32'd2);

    // Blocked spawn leads to OVER.
    bus.top_blocked = 1'b1;
    run_scan(nscan, nsh, fr, lr, sp);
    chk("over_no_spawn", 32'(sp), 32'd0);
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_state", 32'(state), 32'd5);
    chk("over_score_kept", 32'(score), 32'd2);
    bus.top_blocked = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_state", 32'(state), 32'd1);
    @(negedge clk);
    chk("restart_spawn", 32'(bus.spawn), 32'd1);

    // Reset asserted during SHIFT.
    mat[19] = 1'b1;
    @(posedge clk); #1 bus.landed = 1'b1;
    @(posedge clk); #1 bus.landed = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = (state == 3'd4);
    end
    chk("shift_reached", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_shift_state", 32'(state), 32'd0);
    chk("rst_shift_en", 32'(bus.shift_en), 32'd0);
    chk("rst_shift_score", 32'(score), 32'd0);
    chk("rst_shift_spawn", 32'(bus.spawn), 32'd0);
    @(posedge clk); #1 reset = 1'b0; mat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
